// File: rtl/input_debouncer.sv
// Two-channel switch debouncer: 2-flop synchronizer, per-channel stability counter,
// registered edge pulses and a shared saturating count of aborted transitions.
module input_debouncer_lane #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic abort_o
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Plain flop pair; the synchronizer keeps sampling even when frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw_i};
  end

  assign s = sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort_o = 1'b0;
    if (ena) begin
      if (s == clean_q) begin
        cnt_d   = '0;
        abort_o = (cnt_q != '0);
      end else if (cnt_q == LAST) begin
        cnt_d   = '0;
        clean_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

module input_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] raw_in,
  output logic [1:0] clean_out,
  output logic [1:0] rise,
  output logic [1:0] fall,
  output logic [7:0] glitch_cnt
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] abort;
  logic [1:0]        n_abort;
  logic [8:0]        glitch_sum;
  logic [7:0]        glitch_q, glitch_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    input_debouncer_lane #(.STABLE_CYCLES(STABLE_CYCLES)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .raw_i   (raw_in[g]),
      .clean_o (clean_out[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g]),
      .abort_o (abort[g])
    );
  end

  // Aborts are already gated by ena, so the count holds naturally when frozen.
  assign n_abort    = {1'b0, abort[0]} + {1'b0, abort[1]};
  assign glitch_sum = {1'b0, glitch_q} + {7'b0, n_abort};
  assign glitch_d   = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= 8'd0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed table, corner-case sequences and a random
// phase checked against a cycle-level reference model of the debounce rules.
module tb_input_debouncer;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] clean_out, rise, fall;
  logic [7:0] glitch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  input_debouncer #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: raw history (two edges of delay), run length of differing
  // samples per channel, accepted level, pulses and saturating abort count.
  logic [1:0] m_h1, m_h2, m_clean, m_rise, m_fall;
  int         m_run [2];
  int         m_glitch;

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_clean = 0; m_rise = 0; m_fall = 0;
    m_run[0] = 0; m_run[1] = 0; m_glitch = 0;
  endtask

  task automatic model_edge();
    logic [1:0] s;
    int ab;
    s = m_h2; m_h2 = m_h1; m_h1 = raw_in;
    m_rise = 0; m_fall = 0;
    if (ena) begin
      ab = 0;
      for (int c = 0; c < 2; c++) begin
        if (s[c] == m_clean[c]) begin
          if (m_run[c] > 0) ab++;
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_clean[c] = s[c];
            if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
            m_run[c] = 0;
          end
        end
      end
      m_glitch = (m_glitch + ab > 255) ? 255 : m_glitch + ab;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_clean", {6'b0, clean_out}, {6'b0, m_clean});
    chk("m_rise",  {6'b0, rise},      {6'b0, m_rise});
    chk("m_fall",  {6'b0, fall},      {6'b0, m_fall});
    chk("m_glitch", glitch_cnt, 8'(m_glitch));
  endtask

  // One rising edge: model sees the inputs present at the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  // Called just after an edge: reset asserts asynchronously, released mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_clean",  {6'b0, clean_out}, 8'h00);
    chk("rst_rise",   {6'b0, rise},      8'h00);
    chk("rst_fall",   {6'b0, fall},      8'h00);
    chk("rst_glitch", glitch_cnt,        8'h00);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       ena;
    logic [1:0] raw;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [7:0] glitch;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row k is applied before edge k+1 counted from reset release.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0};
    tbl[5]  = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 8'd0};
    tbl[6]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd0};
    tbl[7]  = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0};
    tbl[8]  = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0};
    tbl[9]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd0};
    tbl[10] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd0};
    tbl[11] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd1};
    tbl[12] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd1};

    model_reset();
    #3;
    do_reset();

    // Rise after STABLE+2 edges, then a two-cycle dropout that aborts.
    foreach (tbl[i]) begin
      ena = tbl[i].ena;
      raw_in = tbl[i].raw;
      step();
      chk("tbl_clean",  {6'b0, clean_out}, {6'b0, tbl[i].clean});
      chk("tbl_rise",   {6'b0, rise},      {6'b0, tbl[i].rise});
      chk("tbl_fall",   {6'b0, fall},      {6'b0, tbl[i].fall});
      chk("tbl_glitch", glitch_cnt,        tbl[i].glitch);
    end

    // Both channels accepted on the same edge.
    do_reset();
    raw_in = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("both_pre", {6'b0, clean_out}, 8'h00);
    end
    step();
    chk("both_clean", {6'b0, clean_out}, 8'h03);
    chk("both_rise",  {6'b0, rise},      8'h03);
    step();
    chk("both_rise_end", {6'b0, rise}, 8'h00);

    // Drive the glitch count to 254, then saturate.
    do_reset();
    for (int i = 0; i < 127; i++) begin
      raw_in = 2'b11; step();
      raw_in = 2'b00; step();
    end
    step(); step();
    chk("sat_254", glitch_cnt, 8'd254);
    raw_in = 2'b11; step();
    raw_in = 2'b00; step();
    step(); step();
    chk("sat_255", glitch_cnt, 8'd255);
    raw_in = 2'b01; step();
    raw_in = 2'b00; step();
    step(); step();
    chk("sat_hold", glitch_cnt, 8'd255);
    chk("sat_clean", {6'b0, clean_out}, 8'h00);

    // Reset mid-count, then a clean restart.
    raw_in = 2'b01;
    for (int e = 0; e < 4; e++) step();
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rr_pre", {6'b0, clean_out | rise}, 8'h00);
    end
    step();
    chk("rr_rise",  {6'b0, rise},      8'h01);
    chk("rr_clean", {6'b0, clean_out}, 8'h01);
    step();
    chk("rr_rise_end", {6'b0, rise}, 8'h00);

    // Frozen while inputs toggle.
    ena = 1'b0;
    for (int e = 0; e < 10; e++) begin
      raw_in = 2'($urandom_range(3));
      step();
      chk("frz_clean",  {6'b0, clean_out}, 8'h01);
      chk("frz_glitch", glitch_cnt,        8'd0);
      chk("frz_pulse",  {4'b0, rise, fall}, 8'h00);
    end

    // Random phase, checked against the model every edge.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(4) == 0) raw_in[c] = ~raw_in[c];
      ena = ($urandom_range(9) != 0);
      if ($urandom_range(599) == 0) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL provide parameter: STABLE_CYCLES, default 4, consecutive stable cycles required to accept a level change; legal range 2..255.
REQ-002 SHALL provide port: clk  input  1  single design clock; all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: ena  input  1  enable; 1 = run, 0 = freeze.
REQ-005 SHALL provide port: raw_in  input  2  asynchronous switch/pad inputs; [0] = gate input A, [1] = gate input B.
REQ-006 SHALL provide port: clean_out  output  2  debounced levels; [0] drives A, [1] drives B of the downstream NAND stage.
REQ-007 SHALL provide port: rise  output  2  one-cycle pulse per channel on accepted 0->1 change.
REQ-008 SHALL provide port: fall  output  2  one-cycle pulse per channel on accepted 1->0 change.
REQ-009 SHALL provide port: glitch_cnt  output  8  saturating count of aborted transitions, both channels combined.

Function
REQ-010 SHALL pass each raw_in bit through a 2-flop synchronizer; s[i] = second-flop output; no logic between the two flops.
REQ-011 SHALL keep one counter per channel, width ceil(log2(STABLE_CYCLES)), independent of the other channel.
REQ-012 SHALL, on each edge with ena=1 and s[i]==clean_out[i]: cnt[i] <= 0.
REQ-013 SHALL, on each edge with ena=1, s[i]!=clean_out[i], cnt[i]<STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
REQ-014 SHALL, on each edge with ena=1, s[i]!=clean_out[i], cnt[i]==STABLE_CYCLES-1: clean_out[i] <= s[i], cnt[i] <= 0.
REQ-015 SHALL register rise[i]/fall[i] so they are high exactly in the cycle where clean_out[i] first shows the new value, and low all other cycles.
REQ-016 SHALL give latency: raw_in[i] change first sampled at edge 1 -> clean_out[i] updates at edge STABLE_CYCLES+2 if raw_in[i] holds steady throughout.
REQ-017 SHALL treat an aborted transition as: ena=1, cnt[i]!=0, s[i]==clean_out[i]; each occurrence adds 1 to glitch_cnt.
REQ-018 SHALL add 2 when both channels abort in the same cycle; glitch_cnt saturates at 255 (254+2 -> 255, 255+n -> 255), never wraps.
REQ-019 SHALL, with ena=0: synchronizer flops keep sampling; cnt, clean_out, glitch_cnt hold; rise/fall forced 0 on next edge.
REQ-020 SHALL treat channels independently: simultaneous acceptance on both channels produces both pulses in the same cycle.
REQ-021 SHALL never update clean_out from s within fewer than STABLE_CYCLES consecutive differing cycles; any single matching cycle restarts the count.

Reset
REQ-022 SHALL, while rst_n=0, force asynchronously: synchronizer flops 0, cnt 0, clean_out 2'b00, rise 2'b00, fall 2'b00, glitch_cnt 8'd0.
REQ-023 SHALL discard any in-progress count on reset mid-operation and generate no pulse for it.
REQ-024 SHALL resume operation from the first rising edge after rst_n deasserts, with no spurious pulse when raw_in=0.

Verification
REQ-025 SHALL cover: STABLE_CYCLES=4, raw_in 00->01 held -> clean_out[0]=1 and rise[0]=1 at edge 6, rise[0]=0 at edge 7, glitch_cnt=0.
REQ-026 SHALL cover: clean_out=01, raw_in[0] low for 2 cycles then high -> clean_out stays 01, no fall pulse, glitch_cnt increments by 1.
REQ-027 SHALL cover: raw_in 00->11 on one edge -> rise=11 on the same single cycle, clean_out=11.
REQ-028 SHALL cover: glitch_cnt preloaded to 254 via repeated glitches, then simultaneous aborts on both channels -> 255; a further glitch -> stays 255.
REQ-029 SHALL cover: rst_n pulsed low mid-count (cnt[0]=2) -> all outputs 0 immediately; after release with raw_in[0]=1 held -> rise[0] at edge STABLE_CYCLES+2.
REQ-030 SHALL cover: ena=0 for 10 cycles while raw_in toggles -> clean_out, glitch_cnt unchanged, rise=fall=00.
